// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO peripheral: register offsets and bus width.
package gpio_pkg;

    localparam int APB_DW = 32;

    // Word offsets, decoded from PADDR[4:2].
    typedef enum logic [2:0] {
        GPIO_MODE       = 3'd0,
        GPIO_IDR        = 3'd1,
        GPIO_ODR        = 3'd2,
        GPIO_ODR_SET    = 3'd3,
        GPIO_ODR_CLR    = 3'd4,
        GPIO_IRQ_EN     = 3'd5,
        GPIO_IRQ_EDGE   = 3'd6,
        GPIO_IRQ_STATUS = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with edge detection; outputs SYNC_STAGES cycles behind the pin.
// Edges are suppressed until the arm counter reaches SYNC_STAGES+1 after reset.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    arm_q;
    logic             armed;

    assign armed = (arm_q == CW'(ARM_MAX));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_q <= arm_q + 1'b1;
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = armed ? ( sync_o & ~prev_q) : '0;
    assign fall_o = armed ? (~sync_o &  prev_q) : '0;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: one wait state per transfer, registered PREADY/PRDATA/PSLVERR.
// Sticky W1C edge interrupts; a write to IDR answers PSLVERR and changes nothing.
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  inoutPort
);

    logic [WIDTH-1:0] mode_q, mode_d, odr_q, odr_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d, irq_edge_q, irq_edge_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             pready_q, pready_d, pslverr_q, pslverr_d;
    logic [APB_DW-1:0] prdata_q, prdata_d, rdata_mux;

    logic [WIDTH-1:0] pin_in, sync, rise, fall, set_mask, w1c_mask, wdat;
    gpio_reg_e        reg_sel;
    logic             access_first, commit, wr_commit, bad_wr;
    logic             unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign reg_sel      = gpio_reg_e'(PADDR[4:2]);
    assign wdat         = PWDATA[WIDTH-1:0];
    assign access_first = PSEL & PENABLE & ~pready_q;
    assign commit       = PSEL & PENABLE & pready_q & ~pslverr_q;
    assign wr_commit    = commit & PWRITE;
    assign bad_wr       = PWRITE & (reg_sel == GPIO_IDR);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign inoutPort[i] = mode_q[i] ? odr_q[i] : 1'bz;
    end
    assign pin_in = inoutPort;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (PCLK),
        .rst_ni (PRESET),
        .pin_i  (pin_in),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Only input pins raise status; direction/polarity changes are evaluated live.
    assign set_mask = ((rise & irq_edge_q) | (fall & ~irq_edge_q)) & ~mode_q;
    assign w1c_mask = (wr_commit && reg_sel == GPIO_IRQ_STATUS) ? wdat : '0;

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            GPIO_MODE:       rdata_mux = APB_DW'(mode_q);
            GPIO_IDR:        rdata_mux = APB_DW'(sync);
            GPIO_ODR:        rdata_mux = APB_DW'(odr_q);
            GPIO_IRQ_EN:     rdata_mux = APB_DW'(irq_en_q);
            GPIO_IRQ_EDGE:   rdata_mux = APB_DW'(irq_edge_q);
            GPIO_IRQ_STATUS: rdata_mux = APB_DW'(status_q);
            default:         rdata_mux = '0;
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        odr_d      = odr_q;
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        // Set after clear so a coincident edge is never lost.
        status_d   = (status_q & ~w1c_mask) | set_mask;
        pready_d   = access_first;
        pslverr_d  = access_first & bad_wr;
        prdata_d   = (access_first & ~PWRITE) ? rdata_mux : '0;
        if (wr_commit) begin
            case (reg_sel)
                GPIO_MODE:     mode_d     = wdat;
                GPIO_ODR:      odr_d      = wdat;
                GPIO_ODR_SET:  odr_d      = odr_q | wdat;
                GPIO_ODR_CLR:  odr_d      = odr_q & ~wdat;
                GPIO_IRQ_EN:   irq_en_d   = wdat;
                GPIO_IRQ_EDGE: irq_edge_d = wdat;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            mode_q     <= '0;
            odr_q      <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
            status_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
        end else begin
            mode_q     <= mode_d;
            odr_q      <= odr_d;
            irq_en_q   <= irq_en_d;
            irq_edge_q <= irq_edge_d;
            status_q   <= status_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;
    assign irq     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq: register table plus hand-written edge/race/reset sequences.
module tb_apb_gpio_irq;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    localparam logic [4:0] A_MODE = 5'h00, A_IDR = 5'h04, A_ODR = 5'h08, A_SET = 5'h0C,
                           A_CLR = 5'h10, A_EN = 5'h14, A_EDGE = 5'h18, A_STAT = 5'h1C;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, irq;
    wire  [WIDTH-1:0] pins;
    logic [WIDTH-1:0] tb_oe = '1, tb_val = '1;

    int checks = 0;
    int errors = 0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    apb_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .irq(irq), .inoutPort(pins)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int n;
        logic got;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("pready_first_access", {31'd0, PREADY}, 32'd0);
        n = 0; got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge PCLK); #1;
            n++;
            if (PREADY) got = 1'b1;
        end
        chk("pready_wait_cycles", 32'(n), 32'd1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        chk("pready_single_cycle", {31'd0, PREADY}, 32'd0);
        chk("prdata_idle_zero", PRDATA, 32'd0);
    endtask

    task automatic wr_ok(input logic [4:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic e;
        apb(1'b1, addr, wdata, rd, e);
        chk("write_pslverr", {31'd0, e}, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic e;
        apb(1'b0, addr, 32'd0, rd, e);
        chk(name, rd, exp);
        chk("read_pslverr", {31'd0, e}, 32'd0);
    endtask

    function automatic vec_t mk(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int first;
        logic [31:0] rd;
        logic e;

        vecs[0]  = mk(1, A_MODE, 32'h0F,       0,     0);
        vecs[1]  = mk(1, A_ODR,  32'hA5,       0,     0);
        vecs[2]  = mk(0, A_MODE, 0,            32'h0F, 0);
        vecs[3]  = mk(0, A_ODR,  0,            32'hA5, 0);
        vecs[4]  = mk(0, A_IDR,  0,            32'hF5, 0);
        vecs[5]  = mk(1, A_SET,  32'h02,       0,     0);
        vecs[6]  = mk(1, A_CLR,  32'h01,       0,     0);
        vecs[7]  = mk(0, A_ODR,  0,            32'hA6, 0);
        vecs[8]  = mk(0, A_IDR,  0,            32'hF6, 0);
        vecs[9]  = mk(0, A_SET,  0,            32'h00, 0);
        vecs[10] = mk(0, A_CLR,  0,            32'h00, 0);
        vecs[11] = mk(1, A_IDR,  32'h55,       0,     1);
        vecs[12] = mk(0, A_IDR,  0,            32'hF6, 0);
        vecs[13] = mk(1, A_EDGE, 32'hFFFFFF10, 0,     0);
        vecs[14] = mk(0, A_EDGE, 0,            32'h10, 0);
        vecs[15] = mk(1, A_EN,   32'h10,       0,     0);
        vecs[16] = mk(0, A_EN,   0,            32'h10, 0);
        vecs[17] = mk(0, A_STAT, 0,            32'h00, 0);

        // Reset with all pins driven high
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pready",  {31'd0, PREADY},  32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_prdata",  PRDATA,           32'd0);
        chk("rst_irq",     {31'd0, irq},     32'd0);
        PRESET = 1'b1;
        idle(10);
        rd_chk("rst_status", A_STAT, 32'h00);
        chk("rst_irq_after", {31'd0, irq}, 32'd0);
        rd_chk("rst_idr", A_IDR, 32'hFF);
        rd_chk("rst_mode", A_MODE, 32'h00);

        // Upper bits above WIDTH are dropped
        wr_ok(A_EDGE, 32'hFFFFFFFF);
        rd_chk("edge_width_mask", A_EDGE, 32'hFF);
        tb_oe = 8'hF0;

        for (int i = 0; i < 18; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e);
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
            idle(2);
        end
        chk("pins_low_nibble", {28'd0, pins[3:0]}, 32'h6);

        // Pin4: falling ignored, rising sets after SYNC+1 cycles
        tb_val[4] = 1'b0;
        idle(6);
        rd_chk("pin4_fall_no_set", A_STAT, 32'h00);
        first = 0;
        tb_val[4] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge PCLK); #1;
            if (irq && first == 0) first = k;
        end
        chk("irq_latency", 32'(first), 32'(SYNC + 1));
        rd_chk("pin4_rise_status", A_STAT, 32'h10);
        wr_ok(A_STAT, 32'h10);
        rd_chk("pin4_w1c", A_STAT, 32'h00);
        chk("pin4_irq_cleared", {31'd0, irq}, 32'd0);
        tb_val[4] = 1'b0;
        idle(6);
        rd_chk("pin4_fall_again", A_STAT, 32'h00);

        // Pin5: status sets while disabled, irq follows enable
        wr_ok(A_EDGE, 32'h30);
        rd_chk("edge_change_no_status", A_STAT, 32'h00);
        tb_val[5] = 1'b0;
        idle(6);
        rd_chk("pin5_fall", A_STAT, 32'h00);
        tb_val[5] = 1'b1;
        idle(6);
        rd_chk("pin5_rise_masked", A_STAT, 32'h20);
        chk("pin5_irq_masked", {31'd0, irq}, 32'd0);
        wr_ok(A_EN, 32'h30);
        chk("pin5_irq_enabled", {31'd0, irq}, 32'd1);
        wr_ok(A_STAT, 32'h20);
        chk("pin5_irq_cleared", {31'd0, irq}, 32'd0);

        // Pin2: a set coinciding with W1C commit wins
        wr_ok(A_EDGE, 32'h34);
        tb_val[2] = 1'b1;
        tb_oe[2]  = 1'b1;
        wr_ok(A_MODE, 32'h0B);
        tb_val[2] = 1'b0;
        idle(6);
        tb_val[2] = 1'b1;
        idle(6);
        rd_chk("pin2_rise", A_STAT, 32'h04);
        tb_val[2] = 1'b0;
        idle(6);
        rd_chk("pin2_sticky", A_STAT, 32'h04);
        tb_val[2] = 1'b1;
        wr_ok(A_STAT, 32'h04);
        rd_chk("pin2_set_wins", A_STAT, 32'h04);
        wr_ok(A_STAT, 32'h04);
        rd_chk("pin2_w1c", A_STAT, 32'h00);

        // Reset during an access phase aborts it
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_ODR; PWDATA = 32'hFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("midxfer_pready", {31'd0, PREADY}, 32'd1);
        PRESET = 1'b0;
        #1;
        chk("midxfer_reset_pready", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        idle(2);
        rd_chk("midxfer_mode", A_MODE, 32'h00);
        rd_chk("midxfer_odr", A_ODR, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
Parametrised APB3 GPIO peripheral: WIDTH bidirectional pins with per-pin direction, atomic set/clear of output data, a synchronised input path and per-pin edge-triggered interrupts with sticky W1C status. It sits on the APB bus as one slave alongside the existing peripherals and drives one level interrupt line to the CPU.

Parameters:
WIDTH, 8, number of GPIO pins (1..32); register bits above WIDTH-1 read 0 and ignore writes.
SYNC_STAGES, 2, flip-flop stages on each input pin before IDR and edge logic (2..4).

Ports:
PCLK  in  1  APB clock; the only clock.
PRESET  in  1  asynchronous reset, active-low.
PADDR  in  5  byte address; decoded on PADDR[4:2].
PWDATA  in  32  write data.
PWRITE  in  1  1 = write.
PENABLE  in  1  APB access phase.
PSEL  in  1  slave select.
PRDATA  out  32  read data; valid while PREADY=1.
PREADY  out  1  transfer-complete strobe.
PSLVERR  out  1  error response; valid while PREADY=1.
irq  out  1  level interrupt = |(IRQ_STATUS & IRQ_EN).
inoutPort  inout  WIDTH  GPIO pins.

Behaviour:
- Register map (offset, access): 0x00 MODE RW (1 = output); 0x04 IDR RO (synchronised pin values); 0x08 ODR RW; 0x0C ODR_SET WO (1s set ODR bits, reads 0); 0x10 ODR_CLR WO (1s clear ODR bits, reads 0); 0x14 IRQ_EN RW; 0x18 IRQ_EDGE RW (1 = rising, 0 = falling); 0x1C IRQ_STATUS RW1C.
- Pins: inoutPort[i] = MODE[i] ? ODR[i] : 'z. IDR[i] = sync output for every pin, whether input or output, so output pins read back their driven value.
- APB timing, one wait state:
  - PREADY is registered. It is set on the first cycle with PSEL&PENABLE&!PREADY and cleared the following cycle.
  - The write commit, PRDATA and PSLVERR all occur on the cycle where PSEL&PENABLE&PREADY.
  - PRDATA is registered with PREADY and holds 0 outside a read completion.
  - PREADY must never stay high for 2 consecutive cycles.
- PSLVERR is asserted for a write to IDR. When PSLVERR is asserted, no state changes; a read of IDR is legal. All 8 offsets are decoded, so no offset is unmapped.
- Input path: a SYNC_STAGES-deep sync chain per pin, reset to 0, followed by a prev register.
  - rise = sync&~prev; fall = ~sync&prev.
- Edge detection arm counter: counts from 0 to SYNC_STAGES+1 after reset. While it is below terminal count, edges are suppressed, so no spurious edge from a pin held high through reset.
- IRQ_STATUS[i] sets on the selected edge when MODE[i]=0 and the counter is armed. It sets regardless of IRQ_EN. It clears only via W1C.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
- Edge latency: a pin transition first shows in IDR SYNC_STAGES cycles later. IRQ_STATUS sets 1 cycle after that, and irq follows combinationally.
- ODR_SET/ODR_CLR act only on the commit cycle; other bits are unchanged. The three ODR writes cannot collide, since one bus transfer occurs per commit.
- Changing IRQ_EDGE or MODE does not clear status; any resulting edge is evaluated normally.
- Reset (async assert, sync deassert by system):
  - MODE, ODR, IRQ_EN, IRQ_EDGE, IRQ_STATUS, sync chain, prev and arm counter all clear to 0.
  - PREADY=0, PRDATA=0, PSLVERR=0, irq=0, all pins high-Z.
- Reset mid-transfer aborts the transfer; the bus restarts from idle.

Decomposition:
- gpio_pkg holds the register offset enum (GPIO_MODE..GPIO_IRQ_STATUS) and the APB data width localparam.
- Sub-module gpio_sync_edge (parameters WIDTH, SYNC_STAGES) contains the sync chain, prev register and arm counter, with outputs sync_o, rise_o, fall_o.
- The top module holds the APB FSM/decode, register file and tristate.

Test Plan:
- Reset with pins driven 0xFF, MODE=0 -> IDR reads 0xFF; IRQ_STATUS=0x00 after 10 cycles; irq=0.
- Write MODE=0x0F, ODR=0xA5 -> pins[3:0]=0x5, pins[7:4]=z; IDR[3:0] reads 0x5. Then ODR_SET=0x02 and ODR_CLR=0x01 -> ODR reads 0xA6.
- IRQ_EN=0x10, IRQ_EDGE=0x10, pin4 toggles 0->1 -> IRQ_STATUS=0x10 exactly SYNC_STAGES+1 cycles after the toggle; irq=1. W1C 0x10 -> status 0, irq=0. A falling edge on pin4 leaves status at 0.
- Pin5 rising edge while IRQ_EN[5]=0 -> status bit 5 set, irq=0; then IRQ_EN=0x20 -> irq=1.
- Rising edge on pin2 landing on the same cycle as a W1C 0x04 commit -> IRQ_STATUS[2] remains 1.
- Any read -> PREADY high exactly one cycle, in the 2nd access cycle. Write to 0x04 -> PSLVERR=1, no register change.
